// File: rtl/vector_mem_sequencer_pkg.sv
// Shared definitions for the vector memory sequencer: lane count, default
// stride, lane-index type and the FSM state encoding.
package vector_mem_sequencer_pkg;

  localparam int NUM_LANES  = 5;
  localparam int STRIDE_DEF = 4;
  localparam int LANE_IDX_W = 3;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  localparam lane_idx_t LAST_LANE = lane_idx_t'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } seq_state_t;

endpackage

// File: rtl/vector_mem_sequencer_if.sv
// Single-word data-memory port owned by the sequencer while a vector
// load/store is in flight. The memory read is combinational.
interface vector_mem_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic [DATA_WIDTH-1:0] MemWData;
  logic                  MemWE;
  logic [DATA_WIDTH-1:0] MemRData;

  modport master (
    output MemAddr,
    output MemWData,
    output MemWE,
    input  MemRData
  );

  modport slave (
    input  MemAddr,
    input  MemWData,
    input  MemWE,
    output MemRData
  );
endinterface

// File: rtl/vector_mem_sequencer_addr_gen.sv
// Lane address generator: holds the word-aligned base address and the lane
// counter, and produces the current lane byte address plus a last-lane flag.
module vector_mem_sequencer_addr_gen
  import vector_mem_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int STRIDE     = STRIDE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base_in,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output lane_idx_t             lane,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] base_q;
  lane_idx_t             cnt_q;

  // Capture the aligned base on accept; step the lane counter while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      base_q <= {base_in[ADDR_WIDTH-1:2], 2'b00};
      cnt_q  <= '0;
    end else if (advance) begin
      cnt_q  <= (cnt_q == LAST_LANE) ? '0 : cnt_q + lane_idx_t'(1);
    end
  end

  // Address arithmetic wraps naturally modulo 2^ADDR_WIDTH.
  always_comb begin
    addr = base_q + (ADDR_WIDTH'(cnt_q) * ADDR_WIDTH'(STRIDE));
    lane = cnt_q;
    last = (cnt_q == LAST_LANE);
  end

endmodule

// File: rtl/vector_mem_sequencer.sv
// Vector memory sequencer: serialises a 5-lane vector store into single-word
// memory writes, or gathers 5 consecutive words into load lanes, stalling the
// core while it owns the memory port.
module vector_mem_sequencer
  import vector_mem_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRIDE     = STRIDE_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Start,
  input  logic                    IsStore,
  input  logic [ADDR_WIDTH-1:0]   BaseAddr,
  input  logic [DATA_WIDTH-1:0]   VecIn_0,
  input  logic [DATA_WIDTH-1:0]   VecIn_1,
  input  logic [DATA_WIDTH-1:0]   VecIn_2,
  input  logic [DATA_WIDTH-1:0]   VecIn_3,
  input  logic [DATA_WIDTH-1:0]   VecIn_4,
  vector_mem_sequencer_if.master  mem,
  output logic                    Stall,
  output logic                    Done,
  output logic                    LoadValid,
  output logic [DATA_WIDTH-1:0]   LoadData_0,
  output logic [DATA_WIDTH-1:0]   LoadData_1,
  output logic [DATA_WIDTH-1:0]   LoadData_2,
  output logic [DATA_WIDTH-1:0]   LoadData_3,
  output logic [DATA_WIDTH-1:0]   LoadData_4,
  output logic                    MisalignErr
);

  seq_state_t            state;
  logic                  is_store_q;
  logic                  misalign_q;
  logic                  done_q;
  logic                  load_valid_q;
  logic                  misalign_err_q;
  logic [DATA_WIDTH-1:0] lane_q [NUM_LANES];
  logic [DATA_WIDTH-1:0] load_q [NUM_LANES];
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [ADDR_WIDTH-1:0] lane_addr;
  lane_idx_t             lane;
  logic                  last;
  logic                  accept;
  logic                  busy;

  assign accept = (state == ST_IDLE) && Start;
  assign busy   = (state == ST_BUSY);

  vector_mem_sequencer_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRIDE     (STRIDE)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .base_in (BaseAddr),
    .advance (busy),
    .addr    (lane_addr),
    .lane    (lane),
    .last    (last)
  );

  // Sequencer FSM: accept, walk the lanes, then a one-cycle completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      is_store_q     <= 1'b0;
      misalign_q     <= 1'b0;
      done_q         <= 1'b0;
      load_valid_q   <= 1'b0;
      misalign_err_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_q[i] <= '0;
        load_q[i] <= '0;
      end
    end else begin
      done_q         <= 1'b0;
      load_valid_q   <= 1'b0;
      misalign_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state      <= ST_BUSY;
            is_store_q <= IsStore;
            misalign_q <= |BaseAddr[1:0];
            lane_q[0]  <= VecIn_0;
            lane_q[1]  <= VecIn_1;
            lane_q[2]  <= VecIn_2;
            lane_q[3]  <= VecIn_3;
            lane_q[4]  <= VecIn_4;
          end
        end
        ST_BUSY: begin
          if (!is_store_q) begin
            for (int i = 0; i < NUM_LANES; i++) begin
              if (lane == lane_idx_t'(i)) load_q[i] <= mem.MemRData;
            end
          end
          if (last) begin
            state          <= ST_DONE;
            done_q         <= 1'b1;
            load_valid_q   <= !is_store_q;
            misalign_err_q <= misalign_q;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Select the captured store lane addressed by the lane counter.
  always_comb begin
    lane_wdata = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane == lane_idx_t'(i)) lane_wdata = lane_q[i];
    end
  end

  // Stall tracks Start while idle so the accepting cycle already holds the PC.
  always_comb begin
    case (state)
      ST_IDLE: Stall = Start;
      ST_BUSY: Stall = 1'b1;
      default: Stall = 1'b0;
    endcase
  end

  // Memory port drive; the write enable is killed by reset even mid-transfer.
  always_comb begin
    mem.MemAddr  = (state == ST_IDLE) ? BaseAddr : lane_addr;
    mem.MemWE    = busy && is_store_q && !reset;
    mem.MemWData = (busy && is_store_q) ? lane_wdata : '0;
  end

  assign Done        = done_q;
  assign LoadValid   = load_valid_q;
  assign MisalignErr = misalign_err_q;
  assign LoadData_0  = load_q[0];
  assign LoadData_1  = load_q[1];
  assign LoadData_2  = load_q[2];
  assign LoadData_3  = load_q[3];
  assign LoadData_4  = load_q[4];

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Randomised self-checking bench for vector_mem_sequencer with a word memory
// behind the port and a transaction-level reference model.
module tb_vector_mem_sequencer;

  logic        clk;
  logic        reset;
  logic        Start;
  logic        IsStore;
  logic [31:0] BaseAddr;
  logic [31:0] vin [5];
  logic        Stall;
  logic        Done;
  logic        LoadValid;
  logic [31:0] ld [5];
  logic        MisalignErr;

  int checks = 0;
  int errors = 0;

  vector_mem_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mif ();

  vector_mem_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .Start       (Start),
    .IsStore     (IsStore),
    .BaseAddr    (BaseAddr),
    .VecIn_0     (vin[0]),
    .VecIn_1     (vin[1]),
    .VecIn_2     (vin[2]),
    .VecIn_3     (vin[3]),
    .VecIn_4     (vin[4]),
    .mem         (mif),
    .Stall       (Stall),
    .Done        (Done),
    .LoadValid   (LoadValid),
    .LoadData_0  (ld[0]),
    .LoadData_1  (ld[1]),
    .LoadData_2  (ld[2]),
    .LoadData_3  (ld[3]),
    .LoadData_4  (ld[4]),
    .MisalignErr (MisalignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory seen by the DUT, and the model's idea of what it should contain.
  logic [31:0] dmem    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_load [5];
  int          mem_gen = 0;

  function automatic logic [31:0] dmem_rd(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (mif.MemWE) begin
      dmem[mif.MemAddr] = mif.MemWData;
      mem_gen++;
    end
  end

  always @(mif.MemAddr or mem_gen) mif.MemRData = dmem_rd(mif.MemAddr);

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_loads(input string tag);
    for (int i = 0; i < 5; i++) chk($sformatf("%s_ld%0d", tag, i), ld[i], exp_load[i]);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    dmem[a]    = d;
    ref_mem[a] = d;
    mem_gen++;
  endtask

  // One full instruction: accept, 5 lane cycles, DONE, back to IDLE.
  // Inputs are scrambled after accept to confirm they are not re-sampled.
  task automatic xfer(input string tag, input bit st, input logic [31:0] base,
                      input logic [4:0][31:0] lanes, input bit hold_start);
    logic [31:0] abase;
    logic [31:0] a;
    abase    = {base[31:2], 2'b00};
    Start    = 1'b1;
    IsStore  = st;
    BaseAddr = base;
    for (int i = 0; i < 5; i++) vin[i] = lanes[i];
    #1;
    chk({tag, "_acc_stall"}, Stall, 1'b1);
    chk({tag, "_acc_we"}, mif.MemWE, 1'b0);
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      BaseAddr = $urandom;
      IsStore  = 1'($urandom);
      for (int i = 0; i < 5; i++) vin[i] = $urandom;
      @(negedge clk);
      a = abase + 32'(4 * j);
      chk($sformatf("%s_b%0d_stall", tag, j), Stall, 1'b1);
      chk($sformatf("%s_b%0d_done", tag, j), Done, 1'b0);
      chk($sformatf("%s_b%0d_lv", tag, j), LoadValid, 1'b0);
      chk($sformatf("%s_b%0d_we", tag, j), mif.MemWE, st);
      chk($sformatf("%s_b%0d_addr", tag, j), mif.MemAddr, a);
      chk($sformatf("%s_b%0d_wd", tag, j), mif.MemWData, st ? lanes[j] : 32'h0);
      if (st) ref_mem[a] = lanes[j];
      else    exp_load[j] = ref_rd(a);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_done"}, Done, 1'b1);
    chk({tag, "_done_stall"}, Stall, 1'b0);
    chk({tag, "_done_lv"}, LoadValid, !st);
    chk({tag, "_done_mis"}, MisalignErr, |base[1:0]);
    chk({tag, "_done_we"}, mif.MemWE, 1'b0);
    chk({tag, "_done_wd"}, mif.MemWData, 32'h0);
    chk_loads(tag);
    @(posedge clk); #1;
    if (!hold_start) Start = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_done"}, Done, 1'b0);
    chk({tag, "_idle_lv"}, LoadValid, 1'b0);
    chk({tag, "_idle_stall"}, Stall, hold_start);
    chk({tag, "_idle_we"}, mif.MemWE, 1'b0);
    for (int j = 0; j < 5; j++) begin
      a = abase + 32'(4 * j);
      chk($sformatf("%s_mem%0d", tag, j), dmem_rd(a), ref_rd(a));
    end
  endtask

  initial begin
    logic [4:0][31:0] lanes;
    logic [31:0]      rb;
    bit               rst_;

    reset    = 1'b1;
    Start    = 1'b0;
    IsStore  = 1'b0;
    BaseAddr = '0;
    for (int i = 0; i < 5; i++) begin
      vin[i]      = '0;
      exp_load[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", Stall, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_lv", LoadValid, 1'b0);
    chk("rst_mis", MisalignErr, 1'b0);
    chk("rst_we", mif.MemWE, 1'b0);
    chk_loads("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);

    // Basic store
    lanes = {32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    xfer("st100", 1'b1, 32'h100, lanes, 1'b0);

    // Basic load from preloaded words
    for (int i = 0; i < 5; i++) preload(32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
    xfer("ld200", 1'b0, 32'h200, lanes, 1'b0);

    // Start held through DONE: exactly one re-accept from IDLE
    lanes = {32'hE4, 32'hE3, 32'hE2, 32'hE1, 32'hE0};
    xfer("hold1", 1'b1, 32'h400, lanes, 1'b1);
    xfer("hold2", 1'b1, 32'h400, lanes, 1'b0);

    // Address wrap past the top of memory
    lanes = {32'hC4, 32'hC3, 32'hC2, 32'hC1, 32'hC0};
    xfer("wrap", 1'b1, 32'hFFFF_FFF8, lanes, 1'b0);

    // Misaligned base is forced to word alignment and flagged
    lanes = {32'hD4, 32'hD3, 32'hD2, 32'hD1, 32'hD0};
    xfer("mis", 1'b1, 32'h103, lanes, 1'b0);

    // Load back the wrapped words
    xfer("ldwrap", 1'b0, 32'hFFFF_FFF8, lanes, 1'b0);

    // Reset during the 3rd lane cycle of a store
    preload(32'h308, 32'h5A5A_0308);
    Start    = 1'b1;
    IsStore  = 1'b1;
    BaseAddr = 32'h300;
    for (int i = 0; i < 5; i++) vin[i] = 32'hB0 + 32'(i);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_we0", mif.MemWE, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_we_gated", mif.MemWE, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    Start = 1'b0;
    @(negedge clk);
    ref_mem[32'h300] = 32'hB0;
    ref_mem[32'h304] = 32'hB1;
    for (int i = 0; i < 5; i++) exp_load[i] = '0;
    chk("rst_mid_stall", Stall, 1'b0);
    chk("rst_mid_done", Done, 1'b0);
    chk("rst_mid_lv", LoadValid, 1'b0);
    chk("rst_mid_mis", MisalignErr, 1'b0);
    chk("rst_mid_we", mif.MemWE, 1'b0);
    chk_loads("rst_mid");
    for (int j = 0; j < 5; j++) begin
      rb = 32'h300 + 32'(4 * j);
      chk($sformatf("rst_mid_mem%0d", j), dmem_rd(rb), ref_rd(rb));
    end

    // Randomised mix of loads and stores over a small window and near the wrap
    for (int n = 0; n < 12; n++) begin
      rst_ = 1'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                             rb = 32'h1000 + 32'($urandom_range(0, 63));
      for (int i = 0; i < 5; i++) lanes[i] = $urandom;
      xfer($sformatf("rnd%0d", n), rst_, rb, lanes, 1'($urandom_range(0, 1)));
    end
    Start = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
- Downstream of the datapath's vector ALU: serialises a 5-lane vector store (VecWriteData_0..4) into five single-word data-memory writes.
- Also performs the inverse 5-word vector load, gathering ReadData into lanes for the vector register file.
- Stalls the single-cycle core while it owns the memory port; returns control with a one-cycle Done/LoadValid pulse.

Parameters:
- DATA_WIDTH, 32, lane and memory word width.
- ADDR_WIDTH, 32, byte address width.
- STRIDE, 4, byte increment between consecutive lanes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  vector memory instruction present; held high by the core while Stall=1.
- IsStore  in  1  1=store lanes to memory, 0=load lanes from memory; sampled with Start.
- BaseAddr  in  ADDR_WIDTH  lane-0 byte address (the core's ALUResult).
- VecIn_0..VecIn_4  in  DATA_WIDTH each  store data lanes, sampled with Start.
- MemAddr  out  ADDR_WIDTH  data-memory address.
- MemWData  out  DATA_WIDTH  data-memory write data.
- MemWE  out  1  data-memory write enable.
- MemRData  in  DATA_WIDTH  data-memory read data (combinational read).
- Stall  out  1  hold PC/instruction this cycle.
- Done  out  1  one-cycle completion pulse.
- LoadValid  out  1  one-cycle pulse: LoadData_* valid; drives the vector register file write enable.
- LoadData_0..LoadData_4  out  DATA_WIDTH each  gathered load lanes.
- MisalignErr  out  1  pulses with Done if BaseAddr[1:0]!=0.

Behaviour:
- Reset:
  - Values: state IDLE, lane counter 0, LoadData_* 0, captured registers 0, Done/LoadValid/MisalignErr 0.
  - MemWE is gated by !reset, so it is 0 in any cycle where reset=1, including reset mid-transfer.
  - A partial transfer is abandoned; no further writes occur.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Stall = Start (combinational).
  - On an edge with Start=1, capture IsStore, BaseAddr with bits[1:0] forced to 00, a misalign flag, and VecIn_*; clear the counter; go to BUSY.
  - MemWE = 0; MemAddr = BaseAddr (don't-care).
- BUSY:
  - Stall = 1.
  - MemAddr = captured base + counter*STRIDE, modulo 2^ADDR_WIDTH (wraps past 0xFFFFFFFC to 0).
  - Store: MemWE=1, MemWData=captured lane[counter].
  - Load: MemWE=0; at the edge, LoadData_[counter] <= MemRData.
  - Counter increments each edge; on the edge where counter=4, go to DONE.
- DONE, one cycle:
  - Stall=0, Done=1.
  - LoadValid = !captured IsStore; MisalignErr = captured flag.
  - Start is ignored here (same instruction still presented); go to IDLE at the next edge.
- Latency:
  - Accept cycle + 5 BUSY cycles + DONE gives 7 cycles total per instruction.
  - Memory accesses occur in BUSY cycles 1..5.
- Inputs are sampled only at accept; changes to VecIn_*/BaseAddr during BUSY have no effect.
- LoadData_* hold their value until the next load overwrites them; a store does not modify them.
- MemWData = 0 when not in a BUSY store cycle.

Decomposition:
- Shared package (vector_pkg):
  - NUM_LANES=5, STRIDE default, state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10).
  - Lane-index width (3 bits).
- One natural sub-module: vec_lane_addr_gen (base register + counter -> MemAddr, last-lane flag).
- The lane mux and gather registers stay inline.

Test Plan:
1. Store, BaseAddr=0x100, lanes 0x11,0x22,0x33,0x44,0x55 -> MemWE high exactly 5 cycles; writes 0x11@0x100, 0x22@0x104, 0x33@0x108, 0x44@0x10C, 0x55@0x110; Done on cycle 6; Stall low only then.
2. Load, BaseAddr=0x200, memory preloaded 0xA0..0xA4 -> MemWE never high; LoadData_0..4 = 0xA0..0xA4; LoadValid=1 for exactly one cycle, coincident with Done.
3. Start held high through DONE and one extra cycle -> second transfer starts only from IDLE (one re-accept); exactly one set of 5 writes per accepted Start.
4. Wrap: store with BaseAddr=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, 0x8.
5. Misaligned: BaseAddr=0x103 store -> writes at 0x100..0x110; MisalignErr pulses with Done.
6. Reset asserted in the 3rd BUSY cycle of a store -> MemWE=0 that cycle; only 2 words written; next cycle IDLE, Stall=0, outputs at reset values.
